// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode, flag index and state definitions shared by the sequential ALU.
package alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP,
    OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL, OP_SWAP
  } op_t;
  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FH = 1;
  localparam int FC = 0;
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational W-bit ALU slice; cin is the carry/borrow-in or the rotate-in bit.
module alu_slice
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] r,
  output logic         cout,
  output logic         hout
);
  localparam int H = W / 2;
  logic [W:0] sum, dif;
  logic [H:0] hsum, hdif;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    dif  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    hsum = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
    hdif = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]} - {{H{1'b0}}, cin};
    r    = sum[W-1:0];
    cout = sum[W];
    hout = hsum[H];
    case (op)
      OP_SUB, OP_SBC, OP_CP: {r, cout, hout} = {dif[W-1:0], dif[W], hdif[H]};
      OP_AND:  {r, cout, hout} = {a & b, 2'b01};
      OP_XOR:  {r, cout, hout} = {a ^ b, 2'b00};
      OP_OR:   {r, cout, hout} = {a | b, 2'b00};
      OP_RLC:  {r, cout, hout} = {a[W-2:0], a[W-1], a[W-1], 1'b0};
      OP_RRC:  {r, cout, hout} = {a[0], a[W-1:1], a[0], 1'b0};
      OP_RL:   {r, cout, hout} = {a[W-2:0], cin, a[W-1], 1'b0};
      OP_RR:   {r, cout, hout} = {cin, a[W-1:1], a[0], 1'b0};
      OP_SLA:  {r, cout, hout} = {a[W-2:0], 1'b0, a[W-1], 1'b0};
      OP_SRA:  {r, cout, hout} = {a[W-1], a[W-1:1], a[0], 1'b0};
      OP_SRL:  {r, cout, hout} = {1'b0, a[W-1:1], a[0], 1'b0};
      OP_SWAP: {r, cout, hout} = {a[H-1:0], a[W-1:H], 2'b00};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential SM83-style ALU; wide ops run low then high slice through one shared alu_slice.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W       = 8,
  parameter bit WIDE_EN = 1'b1
) (
  input  logic           CLK,
  input  logic           nRESET,
  input  logic           Start,
  input  logic [3:0]     Op,
  input  logic           Wide,
  input  logic [2*W-1:0] A,
  input  logic [2*W-1:0] B,
  input  logic [3:0]     FlagsIn,
  output logic           Busy,
  output logic           Done,
  output logic [2*W-1:0] Res,
  output logic [3:0]     FlagsOut
);
  state_t state;
  op_t op;
  logic wide, c, lo_c, cin, cout, hout, sub, unused_flags;
  logic [2*W-1:0] opa, opb;
  logic [W-1:0] lo, sa, sb, r;
  assign unused_flags = ^FlagsIn[3:1];
  assign Busy = state != IDLE;
  assign sa   = state == HI ? opa[2*W-1:W] : opa[W-1:0];
  assign sb   = state == HI ? opb[2*W-1:W] : opb[W-1:0];
  assign sub  = op == OP_SUB || op == OP_SBC || op == OP_CP;
  // Low slice takes the flag carry only for ops that consume it; high slice chains the low carry.
  assign cin  = state == HI ? lo_c : c & (op == OP_ADC || op == OP_SBC || op == OP_RL || op == OP_RR);
  alu_slice #(.W(W)) slice (.op(op), .a(sa), .b(sb), .cin(cin), .r(r), .cout(cout), .hout(hout));
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      state    <= IDLE;
      op       <= OP_ADD;
      wide     <= 1'b0;
      c        <= 1'b0;
      lo_c     <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      lo       <= '0;
      Done     <= 1'b0;
      Res      <= '0;
      FlagsOut <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          state <= LO;
          op    <= op_t'(Op);
          wide  <= WIDE_EN & Wide & ~Op[3];
          opa   <= A;
          opb   <= B;
          c     <= FlagsIn[FC];
        end
        LO: if (wide) begin
          lo    <= r;
          lo_c  <= cout;
          state <= HI;
        end else begin
          Res      <= {{W{1'b0}}, op == OP_CP ? opa[W-1:0] : r};
          FlagsOut <= {r == '0, sub, hout, cout};
          Done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          Res      <= op == OP_CP ? opa : {r, lo};
          FlagsOut <= {{r, lo} == '0, sub, hout, cout};
          Done     <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (W=8) against an arithmetic reference model.
module tb_alu_seq;
  logic CLK = 1'b0, nRESET = 1'b0, Start = 1'b0, Wide = 1'b0, Busy, Done;
  logic [3:0] Op = '0, FlagsIn = '0, FlagsOut;
  logic [15:0] A = '0, B = '0, Res;
  int checks = 0, failures = 0;

  alu_seq #(.W(8), .WIDE_EN(1'b1)) dut (
    .CLK(CLK), .nRESET(nRESET), .Start(Start), .Op(Op), .Wide(Wide), .A(A), .B(B),
    .FlagsIn(FlagsIn), .Busy(Busy), .Done(Done), .Res(Res), .FlagsOut(FlagsOut)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result and {Z,N,H,C} from whole-word arithmetic; wide ops are one 16-bit computation.
  function automatic logic [19:0] model(input int op, input bit wide, input int a, input int b, input bit ci);
    int mask = wide ? 'hFFFF : 'hFF;
    int hm = wide ? 'hFFF : 'hF;
    int x = a & mask;
    int y = b & mask;
    int c = (op == 1 || op == 3) ? int'(ci) : 0;
    int r = 0;
    int res;
    bit nf = 1'b0, hf = 1'b0, cf = 1'b0;
    case (op)
      0, 1: begin r = x + y + c; hf = ((x & hm) + (y & hm) + c) > hm; cf = r > mask; end
      2, 3, 7: begin r = x - y - c; hf = (x & hm) < (y & hm) + c; cf = x < y + c; nf = 1'b1; end
      4: begin r = x & y; hf = 1'b1; end
      5: r = x ^ y;
      6: r = x | y;
      8: begin r = (x << 1) | (x >> 7); cf = (x >> 7) != 0; end
      9: begin r = (x >> 1) | ((x & 1) << 7); cf = (x & 1) != 0; end
      10: begin r = (x << 1) | int'(ci); cf = (x >> 7) != 0; end
      11: begin r = (x >> 1) | (int'(ci) << 7); cf = (x & 1) != 0; end
      12: begin r = x << 1; cf = (x >> 7) != 0; end
      13: begin r = (x >> 1) | (x & 'h80); cf = (x & 1) != 0; end
      14: begin r = x >> 1; cf = (x & 1) != 0; end
      default: r = (x << 4) | (x >> 4);
    endcase
    r = r & mask;
    res = op == 7 ? x : r;
    return {res[15:0], r == 0, nf, hf, cf};
  endfunction

  task automatic run(input string tag, input logic [3:0] op, input logic wide, input logic [15:0] a,
                     input logic [15:0] b, input logic ci, input logic [15:0] er, input logic [3:0] ef,
                     input int el);
    int cnt = 0;
    @(negedge CLK);
    Op = op; Wide = wide; A = a; B = b; FlagsIn = {3'($urandom), ci}; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0; Op = 4'($urandom); A = 16'($urandom); B = 16'($urandom); FlagsIn = 4'($urandom);
    chk({tag, ".busy"}, Busy, 1);
    do begin @(negedge CLK); cnt++; end while (!Done && cnt < 8);
    chk({tag, ".lat"}, cnt, el);
    chk({tag, ".res"}, Res, er);
    chk({tag, ".flags"}, FlagsOut, ef);
    @(negedge CLK);
    chk({tag, ".done_low"}, Done, 0);
  endtask

  initial begin
    int dn;
    logic [19:0] m;
    repeat (2) @(negedge CLK);
    chk("init.busy", Busy, 0);
    chk("init.done", Done, 0);
    chk("init.res", Res, 0);
    chk("init.flags", FlagsOut, 0);
    nRESET = 1'b1;

    run("add", 4'd0, 1'b0, 16'h003A, 16'h00C6, 1'b0, 16'h0000, 4'b1011, 1);
    run("sbc", 4'd3, 1'b0, 16'h0010, 16'h0001, 1'b1, 16'h000E, 4'b0110, 1);
    run("cp", 4'd7, 1'b0, 16'h0042, 16'h0042, 1'b0, 16'h0042, 4'b1100, 1);
    run("wadd_ovf", 4'd0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1011, 2);
    run("rr", 4'd11, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 4'b1001, 1);
    run("sra", 4'd13, 1'b0, 16'h0081, 16'h0000, 1'b0, 16'h00C0, 4'b0001, 1);
    run("swap", 4'd15, 1'b0, 16'h00F1, 16'h0000, 1'b0, 16'h001F, 4'b0000, 1);
    run("wswap", 4'd15, 1'b1, 16'hABF1, 16'h0000, 1'b0, 16'h001F, 4'b0000, 1);
    run("wadd", 4'd0, 1'b1, 16'h8FFF, 16'h0001, 1'b0, 16'h9000, 4'b0010, 2);

    // Reset while the high slice is pending: outputs clear at once and no completion follows.
    @(negedge CLK);
    Op = 4'd0; Wide = 1'b1; A = 16'h1234; B = 16'h1111; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    chk("rst.in_hi", Busy, 1);
    #1 nRESET = 1'b0;
    #1;
    chk("rst.busy", Busy, 0);
    chk("rst.done", Done, 0);
    chk("rst.res", Res, 0);
    chk("rst.flags", FlagsOut, 0);
    dn = 0;
    repeat (3) begin @(negedge CLK); dn += int'(Done); end
    chk("rst.no_done", dn, 0);
    nRESET = 1'b1;
    run("rst.add", 4'd0, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 1);

    // Start held through a wide op: one completion, then re-acceptance in the Done cycle.
    @(negedge CLK);
    Op = 4'd0; Wide = 1'b1; A = 16'h00FF; B = 16'h0001; FlagsIn = 4'h0; Start = 1'b1;
    dn = 0;
    for (int i = 0; i < 3; i++) begin @(negedge CLK); dn += int'(Done); end
    chk("hold.done_cnt", dn, 1);
    chk("hold.done_last", Done, 1);
    chk("hold.busy_done", Busy, 0);
    chk("hold.res", Res, 16'h0100);
    @(negedge CLK);
    chk("hold.reaccept", Busy, 1);
    chk("hold.done_off", Done, 0);
    Start = 1'b0;
    @(negedge CLK);
    chk("hold.done_mid", Done, 0);
    @(negedge CLK);
    chk("hold.done2", Done, 1);
    chk("hold.res2", Res, 16'h0100);

    // Back-to-back narrow ops; operands changed while busy must not disturb the first.
    @(negedge CLK);
    Op = 4'd0; Wide = 1'b0; A = 16'h0005; B = 16'h0003; FlagsIn = 4'h0; Start = 1'b1;
    @(negedge CLK);
    chk("b2b.busy1", Busy, 1);
    Op = 4'd2; A = 16'h0005; B = 16'h0007;
    @(negedge CLK);
    chk("b2b.done1", Done, 1);
    chk("b2b.res1", Res, 16'h0008);
    @(negedge CLK);
    Start = 1'b0;
    chk("b2b.gap", Done, 0);
    chk("b2b.busy2", Busy, 1);
    @(negedge CLK);
    chk("b2b.done2", Done, 1);
    chk("b2b.res2", Res, 16'h00FE);
    chk("b2b.flags2", FlagsOut, 4'b0111);

    for (int i = 0; i < 150; i++) begin
      int op, a, b;
      bit w, ci, we;
      op = int'($urandom_range(15));
      w = 1'($urandom_range(1));
      ci = 1'($urandom_range(1));
      a = int'($urandom_range(16'hFFFF));
      b = int'($urandom_range(16'hFFFF));
      we = w && op < 8;
      m = model(op, we, a, b, ci);
      run("rnd", 4'(op), w, 16'(a), 16'(b), ci, m[19:4], m[3:0], we ? 2 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the single-pass 8-bit CPU ALU.
- Executes SM83-style arithmetic, logic, rotate and shift operations on a W-bit datapath, with a Start/Busy/Done handshake.
- Adds a wide mode: 2W-bit add, subtract and logic operations run as two W-bit slice passes with the carry chained between them, as ADD HL,rr does.
- Sits between the register file / operand buses and the flag register, and is driven by the decoder sequencer.

Parameters:
- W, 8: slice width. Even, >= 4.
- WIDE_EN, 1: when 0, the Wide input is ignored and every operation is narrow.

Ports:
- CLK  in  1: single clock; all state changes on the rising edge.
- nRESET  in  1: asynchronous, active-low reset.
- Start  in  1: request; accepted only when Busy=0.
- Op  in  4: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 RLC, 9 RRC, 10 RL, 11 RR, 12 SLA, 13 SRA, 14 SRL, 15 SWAP.
- Wide  in  1: 2W-bit operation; honoured only for Op 0-7.
- A  in  2W: operand A (narrow uses A[W-1:0]).
- B  in  2W: operand B (narrow uses B[W-1:0]).
- FlagsIn  in  4: {Z,N,H,C}; only C is used, as the carry-in for ADC/SBC/RL/RR.
- Busy  out  1: operation in flight.
- Done  out  1: one-cycle pulse; Res and FlagsOut are valid from this cycle.
- Res  out  2W: result.
- FlagsOut  out  4: {Z,N,H,C}.

Behaviour:
- Reset (async, nRESET=0): state IDLE; Busy=0, Done=0, Res=0, FlagsOut=0; latched operands cleared. Applies even mid-operation; the in-flight op is dropped with no Done.
- States: IDLE, LO, HI.
- IDLE:
  - Start=1 latches Op, Wide (forced 0 if WIDE_EN=0 or Op>=8), A, B and FlagsIn.C, then moves to LO.
  - Start=0 keeps IDLE.
- LO:
  - Computes the low slice and registers it.
  - Narrow: writes Res = {W'0, r}, writes flags, pulses Done, returns to IDLE.
  - Wide: holds the low result and slice carry-out internally, moves to HI.
- HI:
  - Computes the high slice with carry-in = low carry-out.
  - Writes Res = {hi, lo} and flags, pulses Done, returns to IDLE.
- Busy = (state != IDLE). Start while Busy=1 is ignored, with no queuing.
- Latency: with Start sampled at edge k, a narrow op gives Done and Res after edge k+1; a wide op gives them after edge k+2.
- Back-to-back: Start may be high in the Done cycle (Busy=0) and is accepted.
- Res and FlagsOut hold their values until the next completion. Done is 0 in every cycle other than the completion pulse.
- Arithmetic per slice (r = result, cin = carry-in):
  - ADD/ADC: r = a + b + (ADC ? C : 0). C = carry out of the MSB. H = carry out of bit W/2-1. N=0.
  - SUB/SBC: r = a - b - (SBC ? C : 0). C = borrow. H = borrow from bit W/2. N=1.
  - CP: flags as SUB; Res = operand A, unchanged.
  - AND: H=1, N=0, C=0.
  - XOR/OR: N=H=C=0.
  - RLC/RRC: rotate through the MSB/LSB.
  - RL/RR: rotate through the carry-in.
  - SLA: shift left, LSB=0.
  - SRA: shift right, MSB preserved.
  - SRL: shift right, MSB=0.
  - All shifts and rotates: C = bit shifted out, N=H=0.
  - SWAP: exchange the W/2-bit halves; N=H=C=0.
- Z: set when the full result is zero (all 2W bits in wide mode; the SUB result for CP).
- Wide flags: H and C come from the high slice (H = carry/borrow at bit W+W/2-1), N per Op, Z over 2W bits. Logic ops in wide mode apply bitwise per slice; the carry chain is irrelevant.

Decomposition:
- Package alu_seq_pkg holds:
  - the op_t enum (the 16 codes above);
  - flag index constants FZ=3, FN=2, FH=1, FC=0;
  - the state_t enum {IDLE, LO, HI}.
- Sub-module alu_slice: combinational W-bit slice.
  - Inputs: op, a, b, cin.
  - Outputs: r, cout, hout.
  - Instantiated once and time-multiplexed across LO and HI.

Test Plan (W=8):
- ADD narrow: A=0x3A, B=0xC6 -> Res=0x0000, FlagsOut Z=1 N=0 H=1 C=1. Busy high one cycle; Done one cycle after Start was sampled.
- SBC narrow: A=0x10, B=0x01, FlagsIn.C=1 -> Res=0x000E, Z=0 N=1 H=1 C=0. CP with A=B=0x42 -> Res=0x0042, Z=1 N=1 H=0 C=0.
- Wide ADD: A=0x8FFF, B=0x0001 -> Res=0x9000, Z=0 N=0 H=1 C=0, Done two cycles after Start. Wide ADD A=0xFFFF, B=0x0001 -> Res=0x0000, Z=1 C=1.
- Shifts/rotates:
  - RR A=0x01, C=0 -> Res=0x00, Z=1 C=1.
  - SRA A=0x81 -> Res=0xC0, C=1.
  - SWAP A=0xF1 -> Res=0x1F, C=0.
  - Wide=1 with SWAP -> treated as narrow (Done after 1 cycle, Res[15:8]=0).
- Handshake: Start held high during a wide op -> exactly one completion, then a new acceptance in the Done cycle. Two back-to-back narrow ops -> Done pulses on two consecutive-but-one cycles.
- Reset: nRESET low during state HI -> Busy=0, Done=0, Res=0, FlagsOut=0 immediately, no Done pulse. After release, a fresh ADD 0x01+0x01 -> Res=0x0002.
